// File: rtl/rect_plot_pkg.sv
// Shared types and defaults for the rectangle plot arbiter.
// State encoding, default widths and a packed-bus field helper.
package rect_plot_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ  = 2;
   localparam int DEF_X_W      = 8;
   localparam int DEF_Y_W      = 7;
   localparam int DEF_SIZE_W   = 5;
   localparam int DEF_COLOUR_W = 3;

   // LSB position of requester idx's field in a bus packed at width bits per requester
   function automatic int field_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Raster scan counter for one rectangle: cx runs 0..w-1 per row, cy runs 0..h-1.
// Exposes the next position so the owner can register pixel outputs, plus a registered last flag.
module rect_scan_counter #(
   parameter int SIZE_W = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              en,
   input  logic [SIZE_W-1:0] w_in,
   input  logic [SIZE_W-1:0] h_in,
   output logic [SIZE_W-1:0] cx_nxt,
   output logic [SIZE_W-1:0] cy_nxt,
   output logic              last
);

   logic [SIZE_W-1:0] w_r;
   logic [SIZE_W-1:0] h_r;
   logic [SIZE_W-1:0] cx_r;
   logic [SIZE_W-1:0] cy_r;
   logic              last_r;
   logic [SIZE_W-1:0] w_nxt_s;
   logic [SIZE_W-1:0] h_nxt_s;
   logic              last_nxt_s;

   // next scan position and whether it is the final pixel of the rectangle
   always_comb begin
      cx_nxt     = cx_r;
      cy_nxt     = cy_r;
      w_nxt_s    = w_r;
      h_nxt_s    = h_r;
      last_nxt_s = last_r;
      if (load) begin
         cx_nxt     = '0;
         cy_nxt     = '0;
         w_nxt_s    = w_in;
         h_nxt_s    = h_in;
         last_nxt_s = (w_in == SIZE_W'(1)) && (h_in == SIZE_W'(1));
      end else if (en) begin
         if (cx_r == w_r - SIZE_W'(1)) begin
            cx_nxt = '0;
            cy_nxt = cy_r + SIZE_W'(1);
         end else begin
            cx_nxt = cx_r + SIZE_W'(1);
         end
         last_nxt_s = (cx_nxt == w_r - SIZE_W'(1)) && (cy_nxt == h_r - SIZE_W'(1));
      end else begin
         last_nxt_s = last_r;
      end
   end

   // counter and latched size registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_r    <= '0;
         h_r    <= '0;
         cx_r   <= '0;
         cy_r   <= '0;
         last_r <= 1'b0;
      end else begin
         w_r    <= w_nxt_s;
         h_r    <= h_nxt_s;
         cx_r   <= cx_nxt;
         cy_r   <= cy_nxt;
         last_r <= last_nxt_s;
      end
   end

   assign last = last_r;

endmodule

// File: rtl/rect_plot_arbiter.sv
// Shares one pixel-write port between NUM_REQ rectangle drawers, streaming one pixel per clock.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requester index wins.
module rect_plot_arbiter
   import rect_plot_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int X_W      = DEF_X_W,
   parameter int Y_W      = DEF_Y_W,
   parameter int SIZE_W   = DEF_SIZE_W,
   parameter int COLOUR_W = DEF_COLOUR_W
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*X_W-1:0]       req_x,
   input  logic [NUM_REQ*Y_W-1:0]       req_y,
   input  logic [NUM_REQ*SIZE_W-1:0]    req_w,
   input  logic [NUM_REQ*SIZE_W-1:0]    req_h,
   input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic                         busy,
   output logic [X_W-1:0]               plot_x,
   output logic [Y_W-1:0]               plot_y,
   output logic [COLOUR_W-1:0]          plot_colour,
   output logic                         plot_we
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               state_r, state_nxt;
   logic [IDX_W-1:0]     win_r, win_s;
   logic                 found_s;
   logic [X_W-1:0]       x0_r;
   logic [Y_W-1:0]       y0_r;
   logic [NUM_REQ-1:0]   gnt_r, gnt_nxt;
   logic [NUM_REQ-1:0]   done_r, done_nxt;
   logic [X_W-1:0]       plot_x_r, plot_x_nxt;
   logic [Y_W-1:0]       plot_y_r, plot_y_nxt;
   logic [COLOUR_W-1:0]  plot_colour_r, plot_colour_nxt;
   logic                 plot_we_r, plot_we_nxt;
   logic                 load_s;
   logic                 en_s;
   logic [SIZE_W-1:0]    win_w_s;
   logic [SIZE_W-1:0]    win_h_s;
   logic [SIZE_W-1:0]    cx_nxt_s;
   logic [SIZE_W-1:0]    cy_nxt_s;
   logic                 last_s;

`ifdef ROUND_ROBIN_EN
   logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt;
   logic [IDX_W:0]       cand_s;

   // round-robin pick: scanning downward leaves the requester nearest the pointer as winner
   always_comb begin
      found_s = |req;
      win_s   = '0;
      cand_s  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         cand_s = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? cand_s - (IDX_W+1)'(NUM_REQ) : cand_s;
         win_s  = req[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : win_s;
      end
   end

   // pointer moves past the winner once its draw completes
   always_comb begin
      rr_ptr_nxt = rr_ptr_r;
      if (state_r == DONE) begin
         rr_ptr_nxt = (win_r == IDX_W'(NUM_REQ - 1)) ? '0 : win_r + IDX_W'(1);
      end else begin
         rr_ptr_nxt = rr_ptr_r;
      end
   end

   // round-robin pointer register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr_r <= '0;
      end else begin
         rr_ptr_r <= rr_ptr_nxt;
      end
   end
`else
   // fixed priority: lowest set index wins
   always_comb begin
      found_s = |req;
      win_s   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         win_s = req[k] ? IDX_W'(k) : win_s;
      end
   end
`endif

   assign win_w_s = req_w[field_lsb(int'(win_s), SIZE_W) +: SIZE_W];
   assign win_h_s = req_h[field_lsb(int'(win_s), SIZE_W) +: SIZE_W];

   rect_scan_counter #(.SIZE_W(SIZE_W)) u_scan (
      .clk    (clk),
      .resetn (resetn),
      .load   (load_s),
      .en     (en_s),
      .w_in   (win_w_s),
      .h_in   (win_h_s),
      .cx_nxt (cx_nxt_s),
      .cy_nxt (cy_nxt_s),
      .last   (last_s)
   );

   // next state and next values of every registered output
   always_comb begin
      state_nxt       = state_r;
      gnt_nxt         = gnt_r;
      done_nxt        = '0;
      plot_we_nxt     = 1'b0;
      plot_x_nxt      = plot_x_r;
      plot_y_nxt      = plot_y_r;
      plot_colour_nxt = plot_colour_r;
      load_s          = 1'b0;
      en_s            = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               load_s          = 1'b1;
               gnt_nxt         = NUM_REQ'(1) << win_s;
               plot_x_nxt      = req_x[field_lsb(int'(win_s), X_W) +: X_W];
               plot_y_nxt      = req_y[field_lsb(int'(win_s), Y_W) +: Y_W];
               plot_colour_nxt = req_colour[field_lsb(int'(win_s), COLOUR_W) +: COLOUR_W];
               if ((win_w_s == '0) || (win_h_s == '0)) begin
                  state_nxt = DONE;
                  done_nxt  = NUM_REQ'(1) << win_s;
               end else begin
                  state_nxt   = DRAW;
                  plot_we_nxt = 1'b1;
               end
            end else begin
               gnt_nxt = '0;
            end
         end
         DRAW: begin
            if (last_s) begin
               state_nxt = DONE;
               done_nxt  = gnt_r;
            end else begin
               en_s        = 1'b1;
               plot_we_nxt = 1'b1;
               plot_x_nxt  = x0_r + X_W'(cx_nxt_s);
               plot_y_nxt  = y0_r + Y_W'(cy_nxt_s);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // state, latched origin and registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r       <= IDLE;
         win_r         <= '0;
         x0_r          <= '0;
         y0_r          <= '0;
         gnt_r         <= '0;
         done_r        <= '0;
         plot_x_r      <= '0;
         plot_y_r      <= '0;
         plot_colour_r <= '0;
         plot_we_r     <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         gnt_r         <= gnt_nxt;
         done_r        <= done_nxt;
         plot_x_r      <= plot_x_nxt;
         plot_y_r      <= plot_y_nxt;
         plot_colour_r <= plot_colour_nxt;
         plot_we_r     <= plot_we_nxt;
         if (load_s) begin
            win_r <= win_s;
            x0_r  <= plot_x_nxt;
            y0_r  <= plot_y_nxt;
         end else begin
            win_r <= win_r;
            x0_r  <= x0_r;
            y0_r  <= y0_r;
         end
      end
   end

   assign gnt         = gnt_r;
   assign done        = done_r;
   assign busy        = (state_r != IDLE);
   assign plot_x      = plot_x_r;
   assign plot_y      = plot_y_r;
   assign plot_colour = plot_colour_r;
   assign plot_we     = plot_we_r;

endmodule
